// File: rtl/fifo_port_reader.sv
// Output-port read engine: fetches one packet entry from the shared FIFO memory
// byte by byte and streams it onto a valid/ready link, then releases the entry.
module fifo_port_reader #(
  parameter int DEPTH     = 3,
  parameter int WIDTH     = 11,
  parameter int UWIDTH    = 8,
  parameter int PTR_SZ    = 2,
  parameter int PTR_IN_SZ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pkt_valid,
  input  logic [PTR_SZ-1:0]    pkt_ptr,
  output logic                 pkt_ready,
  output logic                 read_en,
  output logic [PTR_SZ-1:0]    raddr,
  output logic [PTR_IN_SZ-1:0] raddr_in,
  input  logic [UWIDTH-1:0]    rdata,
  output logic                 out_valid,
  output logic [UWIDTH-1:0]    out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 done,
  output logic [PTR_SZ-1:0]    done_ptr,
  output logic                 err
);

  localparam int LW = PTR_IN_SZ + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DROP   = 3'd4;

  // Header length field encodes (bytes - 1); one extra bit keeps 2**PTR_IN_SZ from wrapping.
  function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] raw);
    if (raw > LW'(WIDTH)) return LW'(WIDTH);
    return raw;
  endfunction

  logic [2:0]           state_q, state_d;
  logic [PTR_SZ-1:0]    ptr_q, ptr_d;
  logic [PTR_IN_SZ-1:0] idx_q, idx_d;
  logic [LW-1:0]        len_q, len_d;
  logic                 out_valid_q, out_valid_d;
  logic [UWIDTH-1:0]    out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic                 done_q, done_d;
  logic [PTR_SZ-1:0]    done_ptr_q, done_ptr_d;
  logic                 err_q, err_d;

  logic                 ld;
  logic                 is_last;
  logic [LW-1:0]        raw_len;
  logic [LW-1:0]        hdr_len;

  assign ld      = !out_valid_q || out_ready;
  assign is_last = ({1'b0, idx_q} == (len_q - LW'(1)));
  assign raw_len = {1'b0, rdata[PTR_IN_SZ-1:0]} + LW'(1);
  assign hdr_len = sat_len(raw_len);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    len_d       = len_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    done_ptr_d  = done_ptr_q;
    err_d       = 1'b0;
    read_en     = 1'b0;
    raddr_in    = '0;
    case (state_q)
      S_IDLE: begin
        if (pkt_valid) begin
          ptr_d   = pkt_ptr;
          state_d = (int'(pkt_ptr) >= DEPTH) ? S_DROP : S_HDR;
        end
      end
      S_DROP: begin
        done_d     = 1'b1;
        done_ptr_d = ptr_q;
        err_d      = 1'b1;
        state_d    = S_IDLE;
      end
      S_HDR: begin
        read_en     = 1'b1;
        len_d       = hdr_len;
        err_d       = (raw_len > LW'(WIDTH));
        out_data_d  = rdata;
        out_valid_d = 1'b1;
        idx_d       = PTR_IN_SZ'(1);
        if (hdr_len == LW'(1)) begin
          out_last_d = 1'b1;
          state_d    = S_DRAIN;
        end else begin
          out_last_d = 1'b0;
          state_d    = S_STREAM;
        end
      end
      S_STREAM: begin
        // A stalled byte keeps the memory idle so out_data holds its value.
        if (ld) begin
          read_en     = 1'b1;
          raddr_in    = idx_q;
          out_data_d  = rdata;
          out_valid_d = 1'b1;
          out_last_d  = is_last;
          idx_d       = idx_q + PTR_IN_SZ'(1);
          if (is_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          done_ptr_d  = ptr_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      done_ptr_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      done_ptr_q  <= done_ptr_d;
      err_q       <= err_d;
    end
  end

  assign pkt_ready = (state_q == S_IDLE);
  assign raddr     = ptr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign done_ptr  = done_ptr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fifo_port_reader.sv
// Bench for fifo_port_reader: memory model plus a packet-level reference that
// predicts byte sequence, length clamp, error and release for each entry.
module tb_fifo_port_reader;
  localparam int DEPTH = 3;
  localparam int WIDTH = 11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pkt_valid;
  logic [1:0] pkt_ptr;
  logic       pkt_ready;
  logic       read_en;
  logic [1:0] raddr;
  logic [3:0] raddr_in;
  logic [7:0] rdata;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       done;
  logic [1:0] done_ptr;
  logic       err;

  logic [7:0] mem [0:3][0:15];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  assign rdata = mem[raddr][raddr_in];

  fifo_port_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .UWIDTH(8), .PTR_SZ(2), .PTR_IN_SZ(4)) dut (
    .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .pkt_ptr(pkt_ptr), .pkt_ready(pkt_ready),
    .read_en(read_en), .raddr(raddr), .raddr_in(raddr_in), .rdata(rdata),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .done(done), .done_ptr(done_ptr), .err(err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int p, input logic [7:0] hdr);
    mem[p][0] = hdr;
    for (int i = 1; i < 16; i++) mem[p][i] = 8'($urandom);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_pkt_ready"}, int'(pkt_ready), 1);
    chk({pfx, "_out_valid"}, int'(out_valid), 0);
    chk({pfx, "_out_last"}, int'(out_last), 0);
    chk({pfx, "_out_data"}, int'(out_data), 0);
    chk({pfx, "_done"}, int'(done), 0);
    chk({pfx, "_done_ptr"}, int'(done_ptr), 0);
    chk({pfx, "_err"}, int'(err), 0);
    chk({pfx, "_read_en"}, int'(read_en), 0);
  endtask

  // mode 0: out_ready always 1; mode 1: 1,0,0 repeating; mode 2: random.
  task automatic run_pkt(input int p, input int mode, input int abort_k, input bit chk_timing);
    int exp_len, exp_err, nrx, rcnt, errs, err_k, first_k, done_k, ndone, wait_n;
    bit bad, pv_stall, plast;
    logic [7:0] pdata;
    bad = (p >= DEPTH);
    exp_len = bad ? 0 : (int'(mem[p][0]) % 16) + 1;
    exp_err = bad ? 1 : int'(exp_len > WIDTH);
    if (exp_len > WIDTH) exp_len = WIDTH;
    nrx = 0; rcnt = 0; errs = 0; err_k = -1; first_k = -1; done_k = -1; ndone = 0;
    pv_stall = 0; plast = 0; pdata = '0;

    @(negedge clk);
    wait_n = 0;
    while (!pkt_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    chk("pkt_ready_offer", int'(pkt_ready), 1);
    pkt_valid = 1'b1;
    pkt_ptr   = 2'(p);
    out_ready = 1'b0;
    @(negedge clk);
    pkt_valid = 1'b0;
    pkt_ptr   = 2'($urandom);

    for (int k = 0; k < 300 && ndone == 0; k++) begin
      if (k > 0) @(negedge clk);
      if (k == abort_k) begin
        chk("abort_byte2", int'(out_data), int'(mem[p][2]));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int j = 0; j < 8; j++) begin
          @(negedge clk);
          if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        return;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((k % 3) == 0);
        default: out_ready = 1'($urandom);
      endcase
      #1;
      if (pv_stall) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(pdata));
        chk("hold_last", int'(out_last), int'(plast));
      end
      if (out_valid && !out_ready) chk("rd_stall", int'(read_en), 0);
      if (read_en) begin
        chk("raddr", int'(raddr), p);
        chk("raddr_in", int'(raddr_in), rcnt);
        rcnt++;
      end
      if (out_valid && first_k < 0) first_k = k;
      if (out_valid && out_ready) begin
        if (nrx < 16) chk("byte", int'(out_data), int'(mem[p][nrx]));
        chk("last", int'(out_last), int'(nrx == exp_len - 1));
        nrx++;
      end
      if (err) begin
        errs++;
        err_k = k;
      end
      if (done) begin
        ndone++;
        done_k = k;
        chk("done_ptr", int'(done_ptr), p);
        chk("ready_at_done", int'(pkt_ready), 1);
      end
      pv_stall = out_valid && !out_ready;
      pdata    = out_data;
      plast    = out_last;
    end

    chk("done_seen", ndone, 1);
    chk("byte_count", nrx, exp_len);
    chk("read_count", rcnt, exp_len);
    chk("err_count", errs, exp_err);
    if (exp_err != 0) chk("err_cycle", err_k, 1);
    chk("first_valid_cycle", first_k, bad ? -1 : 1);
    if (chk_timing) chk("done_cycle", done_k, bad ? 1 : exp_len + 1);
    @(negedge clk);
    #1;
    chk("done_pulse", int'(done), 0);
    chk("err_pulse", int'(err), 0);
    chk("valid_after", int'(out_valid), 0);
  endtask

  initial begin
    int p, mode;
    rst_n     = 1'b0;
    pkt_valid = 1'b0;
    pkt_ptr   = '0;
    out_ready = 1'b0;
    for (int e = 0; e < 4; e++) fill(e, 8'($urandom));
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    fill(1, 8'h03);
    run_pkt(1, 0, -1, 1'b1);
    run_pkt(1, 1, -1, 1'b0);
    fill(2, 8'h0F);
    run_pkt(2, 0, -1, 1'b1);
    fill(0, 8'h00);
    run_pkt(0, 0, -1, 1'b1);
    run_pkt(0, 1, -1, 1'b0);
    run_pkt(3, 0, -1, 1'b1);
    fill(0, 8'h05);
    run_pkt(0, 0, 3, 1'b0);
    fill(1, 8'h35);
    run_pkt(1, 2, -1, 1'b0);

    for (int n = 0; n < 30; n++) begin
      p = $urandom_range(0, 3);
      if (p < DEPTH) fill(p, 8'($urandom));
      mode = $urandom_range(0, 2);
      run_pkt(p, mode, -1, mode == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
